// File: rtl/ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl
// Purpose  : Request-driven initiator for a synchronous single-port RAM
//            (1-cycle registered read, write on the clock edge when we = 1).
//            Clients issue reads/writes over a valid/ready handshake; read
//            data comes back with a one-cycle rsp_valid pulse, three cycles
//            after accept. A fill engine writes one value to every address
//            (used to clear the VGA framebuffer).
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            req_valid/req_ready  - request handshake (req_ready is combinational)
//            req_we/addr/wdata    - request type, address, write data
//            rsp_valid/rsp_data   - read response pulse and data
//            fill_start/value     - start a fill (sampled in IDLE) and its data
//            busy                 - fill in progress
//            mem_addr/din/we      - registered RAM port outputs
//            mem_dout             - RAM read data (registered inside the RAM)
// Revision : 1.0 - initial release
// ============================================================================
module ram_ctrl #(
    parameter int A = 10,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [A-1:0] req_addr,
    input  logic [D-1:0] req_wdata,
    output logic         rsp_valid,
    output logic [D-1:0] rsp_data,
    input  logic         fill_start,
    input  logic [D-1:0] fill_value,
    output logic         busy,
    output logic [A-1:0] mem_addr,
    output logic [D-1:0] mem_din,
    output logic         mem_we,
    input  logic [D-1:0] mem_dout
);

    localparam logic [A-1:0] c_last_addr = {A{1'b1}};
    localparam logic [A-1:0] c_one       = {{(A-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [A-1:0]   r_fill_cnt;
    logic [D-1:0]   r_fill_val;
    logic [1:0]     r_rd_pipe;
    logic           w_accept;
    logic           w_fill_go;
    logic           w_fill_last;

    // A pending fill_start blocks requests so the fill wins the port.
    assign req_ready   = (r_state == ST_IDLE) && !fill_start;
    assign w_accept    = req_valid && req_ready;
    assign w_fill_go   = (r_state == ST_IDLE) && fill_start;
    assign w_fill_last = (r_state == ST_FILL) && (r_fill_cnt == c_last_addr);
    assign busy        = (r_state == ST_FILL);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (fill_start) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_fill_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Fill counter and latched fill value. r_fill_cnt always equals the
    // address currently on mem_addr during FILL; it wraps to 0 naturally
    // after the last address.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill_cnt <= '0;
            r_fill_val <= '0;
        end else if (w_fill_go) begin
            r_fill_cnt <= '0;
            r_fill_val <= fill_value;
        end else if (r_state == ST_FILL) begin
            r_fill_cnt <= r_fill_cnt + c_one;
        end
    end

    // ------------------------------------------------------------------------
    // RAM port registers. The first fill write (address 0) is loaded on the
    // start edge itself so writes occupy exactly the 2^A cycles of FILL.
    // Requests and fill are mutually exclusive because req_ready is low
    // whenever a fill is starting or running.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_din  <= '0;
            mem_we   <= 1'b0;
        end else if (w_accept) begin
            mem_addr <= req_addr;
            mem_din  <= req_wdata;
            mem_we   <= req_we;
        end else if (w_fill_go) begin
            mem_addr <= '0;
            mem_din  <= fill_value;
            mem_we   <= 1'b1;
        end else if ((r_state == ST_FILL) && !w_fill_last) begin
            mem_addr <= r_fill_cnt + c_one;
            mem_din  <= r_fill_val;
            mem_we   <= 1'b1;
        end else begin
            mem_we   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Read tracking: stage 0 = address on the port, stage 1 = mem_dout valid.
    // The response is registered once more, giving a 3-cycle read latency.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pipe <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            r_rd_pipe <= {r_rd_pipe[0], (w_accept && !req_we)};
            rsp_valid <= r_rd_pipe[1];
            if (r_rd_pipe[1]) begin
                rsp_data <= mem_dout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_ctrl
// Purpose  : Directed self-checking bench for ram_ctrl (A=4, D=8) with a
//            synchronous RAM model on the mem_* port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_ctrl;

    localparam int A = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [A-1:0] req_addr;
    logic [D-1:0] req_wdata;
    logic         rsp_valid;
    logic [D-1:0] rsp_data;
    logic         fill_start;
    logic [D-1:0] fill_value;
    logic         busy;
    logic [A-1:0] mem_addr;
    logic [D-1:0] mem_din;
    logic         mem_we;
    logic [D-1:0] mem_dout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    ram_ctrl #(.A(A), .D(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .busy       (busy),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_we     (mem_we),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Synchronous single-port RAM model
    logic [D-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    // Response log: cycle index and data of every rsp_valid pulse
    int           rsp_cyc [$];
    logic [D-1:0] rsp_dat [$];
    always @(negedge clk) begin
        if (rsp_valid) begin
            rsp_cyc.push_back(cyc_cnt);
            rsp_dat.push_back(rsp_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        rsp_cyc.delete();
        rsp_dat.delete();
    endtask

    task automatic drive_req(input logic v, input logic we, input logic [A-1:0] a, input logic [D-1:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_req(1'b0, 1'b0, 4'd0, 8'd0);
        fill_start = 1'b0;
        fill_value = 8'd0;
        repeat (2) cyc();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if ({mem_we, mem_addr, mem_din} !== {1'b0, 4'd0, 8'd0}) begin n_fail++;
            $display("FAIL reset_mem: got we=%b addr=%0d din=%h want 0/0/00", mem_we, mem_addr, mem_din); end
        n_checks++; if ({rsp_valid, rsp_data} !== {1'b0, 8'd0}) begin n_fail++;
            $display("FAIL reset_rsp: got valid=%b data=%h want 0/00", rsp_valid, rsp_data); end
        reset = 1'b0;
        cyc();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_write_read();
        int n;
        clr_q();
        n = cyc_cnt;
        drive_req(1'b1, 1'b1, 4'd3, 8'hA5);
        cyc();
        n_checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 4'd3, 8'hA5}) begin n_fail++;
            $display("FAIL wr_port: got we=%b addr=%0d din=%h want 1/3/a5", mem_we, mem_addr, mem_din); end
        drive_req(1'b1, 1'b0, 4'd3, 8'h00);
        cyc();
        n_checks++; if ({mem_we, mem_addr} !== {1'b0, 4'd3}) begin n_fail++;
            $display("FAIL rd_port: got we=%b addr=%0d want 0/3", mem_we, mem_addr); end
        drive_req(1'b0, 1'b0, 4'd0, 8'd0);
        repeat (6) cyc();
        n_checks++; if (rsp_cyc.size() != 1) begin n_fail++;
            $display("FAIL wr_rd_count: got %0d responses want 1", rsp_cyc.size()); end
        if (rsp_cyc.size() > 0) begin
            n_checks++; if (rsp_cyc[0] != n + 4) begin n_fail++;
                $display("FAIL wr_rd_cycle: got cycle %0d want %0d", rsp_cyc[0], n + 4); end
            n_checks++; if (rsp_dat[0] !== 8'hA5) begin n_fail++;
                $display("FAIL wr_rd_data: got %h want a5", rsp_dat[0]); end
        end
    endtask

    task automatic test_back_to_back();
        int r;
        clr_q();
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 1'b1, 4'(i), 8'(8'h10 + i));
            cyc();
            n_checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 4'(i), 8'(8'h10 + i)}) begin n_fail++;
                $display("FAIL b2b_wr_port[%0d]: got we=%b addr=%0d din=%h", i, mem_we, mem_addr, mem_din); end
        end
        r = cyc_cnt;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 1'b0, 4'(i), 8'd0);
            cyc();
        end
        drive_req(1'b0, 1'b0, 4'd0, 8'd0);
        repeat (8) cyc();
        n_checks++; if (rsp_cyc.size() != 4) begin n_fail++;
            $display("FAIL b2b_count: got %0d responses want 4", rsp_cyc.size()); end
        for (int i = 0; i < 4; i++) begin
            if (rsp_cyc.size() > i) begin
                n_checks++; if (rsp_cyc[i] != r + 3 + i || rsp_dat[i] !== 8'(8'h10 + i)) begin n_fail++;
                    $display("FAIL b2b_rsp[%0d]: got cycle %0d data %h want cycle %0d data %h",
                             i, rsp_cyc[i], rsp_dat[i], r + 3 + i, 8'(8'h10 + i)); end
            end
        end
    endtask

    task automatic test_fill();
        int r;
        clr_q();
        fill_start = 1'b1;
        fill_value = 8'h3C;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_start_ready: got %b want 0", req_ready); end
        cyc();
        fill_start = 1'b0;
        fill_value = 8'h00;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if ({busy, req_ready} !== 2'b10) begin n_fail++;
                $display("FAIL fill_busy[%0d]: got busy=%b ready=%b want 1/0", i, busy, req_ready); end
            n_checks++; if ({mem_we, mem_addr, mem_din} !== {1'b1, 4'(i), 8'h3C}) begin n_fail++;
                $display("FAIL fill_port[%0d]: got we=%b addr=%0d din=%h want 1/%0d/3c", i, mem_we, mem_addr, mem_din, i); end
            if (i == 5) fill_start = 1'b1;
            if (i == 6) fill_start = 1'b0;
            cyc();
        end
        n_checks++; if ({busy, mem_we, req_ready} !== 3'b001) begin n_fail++;
            $display("FAIL fill_end: got busy=%b we=%b ready=%b want 0/0/1", busy, mem_we, req_ready); end
        r = cyc_cnt;
        for (int i = 0; i < 16; i++) begin
            drive_req(1'b1, 1'b0, 4'(i), 8'd0);
            cyc();
        end
        drive_req(1'b0, 1'b0, 4'd0, 8'd0);
        repeat (6) cyc();
        n_checks++; if (rsp_cyc.size() != 16) begin n_fail++;
            $display("FAIL fill_rd_count: got %0d want 16", rsp_cyc.size()); end
        for (int i = 0; i < 16; i++) begin
            if (rsp_cyc.size() > i) begin
                n_checks++; if (rsp_cyc[i] != r + 3 + i || rsp_dat[i] !== 8'h3C) begin n_fail++;
                    $display("FAIL fill_rd[%0d]: got cycle %0d data %h want cycle %0d data 3c",
                             i, rsp_cyc[i], rsp_dat[i], r + 3 + i); end
            end
        end
    endtask

    task automatic test_req_vs_fill();
        int f;
        int acc;
        clr_q();
        f = cyc_cnt;
        drive_req(1'b1, 1'b0, 4'd2, 8'd0);
        fill_start = 1'b1;
        fill_value = 8'h55;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready: got %b want 0", req_ready); end
        cyc();
        fill_start = 1'b0;
        acc = -1;
        for (int k = 0; k < 40; k++) begin
            if (req_ready === 1'b1) begin
                acc = cyc_cnt;
                break;
            end
            cyc();
        end
        n_checks++; if (acc != f + 17) begin n_fail++;
            $display("FAIL prio_accept_cycle: got %0d want %0d", acc, f + 17); end
        cyc();
        drive_req(1'b0, 1'b0, 4'd0, 8'd0);
        repeat (6) cyc();
        n_checks++; if (rsp_cyc.size() != 1) begin n_fail++;
            $display("FAIL prio_count: got %0d want 1", rsp_cyc.size()); end
        if (rsp_cyc.size() > 0) begin
            n_checks++; if (rsp_cyc[0] != f + 20 || rsp_dat[0] !== 8'h55) begin n_fail++;
                $display("FAIL prio_rsp: got cycle %0d data %h want cycle %0d data 55", rsp_cyc[0], rsp_dat[0], f + 20); end
        end
    endtask

    task automatic test_read_before_fill();
        int r;
        clr_q();
        drive_req(1'b1, 1'b1, 4'd9, 8'h99);
        cyc();
        r = cyc_cnt;
        drive_req(1'b1, 1'b0, 4'd9, 8'd0);
        cyc();
        drive_req(1'b0, 1'b0, 4'd0, 8'd0);
        fill_start = 1'b1;
        fill_value = 8'h77;
        cyc();
        fill_start = 1'b0;
        fill_value = 8'h00;
        repeat (20) cyc();
        n_checks++; if (rsp_cyc.size() != 1) begin n_fail++;
            $display("FAIL rbf_count: got %0d want 1", rsp_cyc.size()); end
        if (rsp_cyc.size() > 0) begin
            n_checks++; if (rsp_cyc[0] != r + 3 || rsp_dat[0] !== 8'h99) begin n_fail++;
                $display("FAIL rbf_rsp: got cycle %0d data %h want cycle %0d data 99", rsp_cyc[0], rsp_dat[0], r + 3); end
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (ram[i] !== 8'h77) begin n_fail++;
                $display("FAIL rbf_ram[%0d]: got %h want 77", i, ram[i]); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int r;
        clr_q();
        fill_start = 1'b1;
        fill_value = 8'hE1;
        cyc();
        fill_start = 1'b0;
        repeat (7) cyc();
        n_checks++; if ({mem_we, mem_addr} !== {1'b1, 4'd7}) begin n_fail++;
            $display("FAIL rst_fill_pos: got we=%b addr=%0d want 1/7", mem_we, mem_addr); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if ({busy, mem_we, rsp_valid} !== 3'b000) begin n_fail++;
            $display("FAIL rst_async: got busy=%b we=%b rsp_valid=%b want 0/0/0", busy, mem_we, rsp_valid); end
        n_checks++; if (mem_addr !== 4'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
        cyc();
        reset = 1'b0;
        cyc();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (ram[i] !== ((i < 7) ? 8'hE1 : 8'h77)) begin n_fail++;
                $display("FAIL rst_ram[%0d]: got %h want %h", i, ram[i], (i < 7) ? 8'hE1 : 8'h77); end
        end
        r = cyc_cnt;
        drive_req(1'b1, 1'b0, 4'd7, 8'd0);
        cyc();
        drive_req(1'b0, 1'b0, 4'd0, 8'd0);
        repeat (5) cyc();
        n_checks++; if (rsp_cyc.size() != 1) begin n_fail++;
            $display("FAIL rst_rd_count: got %0d want 1", rsp_cyc.size()); end
        if (rsp_cyc.size() > 0) begin
            n_checks++; if (rsp_cyc[0] != r + 3 || rsp_dat[0] !== 8'h77) begin n_fail++;
                $display("FAIL rst_rd: got cycle %0d data %h want cycle %0d data 77", rsp_cyc[0], rsp_dat[0], r + 3); end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_fill();
        test_req_vs_fill();
        test_read_before_fill();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
